// File: rtl/iram_fetch_arbiter.sv
// iram_fetch_arbiter
// Round-robin arbiter sharing one single-port, 1-cycle-latency instruction
// RAM between NUM_CORES fetch units. At most one fetch is issued per cycle.
// The returned word comes back on a shared bus, tagged by a one-hot
// core_rvalid pulse exactly one cycle after the matching core_gnt pulse.
//
// Handshake (per core): core_req is a level. The core holds core_req and
// its address slice stable until it sees core_gnt. If core_req is still high
// at the edge that ends the gnt cycle, that edge takes it as a new request
// for whatever address is then presented. This lets a single core stream one
// word per cycle. core_rdata is meaningful only while core_rvalid is set.
module iram_fetch_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  output logic [NUM_CORES-1:0]        core_gnt,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic [DATA_W-1:0]           core_rdata,
  output logic [ADDR_W-1:0]           iram_addr,
  output logic [DATA_W-1:0]           iram_data_in,
  input  logic [DATA_W-1:0]           iram_rdata
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  // Per-core address view of the flat address bus.
  logic [ADDR_W-1:0] addr_arr [NUM_CORES];

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_addr
    assign addr_arr[i] = core_addr[i*ADDR_W +: ADDR_W];
  end

  // Arbitration state and the single in-flight fetch slot.
  logic [PTR_W-1:0]     rr_ptr;
  logic                 issue_vld;
  logic [PTR_W-1:0]     issue_tag;

  // Combinational search results.
  int                   cand;
  logic [PTR_W-1:0]     cand_idx;
  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;
  logic                 do_grant;
  logic [NUM_CORES-1:0] gnt_onehot;
  logic [NUM_CORES-1:0] rvalid_onehot;

  // IRAM is only read through this block; the write data port is tied off.
  assign iram_data_in = '0;

  // The IRAM output is already registered, so it is forwarded as-is.
  assign core_rdata = iram_rdata;

  // Round-robin search: start just after the last winner and take the first
  // requesting core, wrapping around the core index range.
  always_comb begin
    cand      = 0;
    cand_idx  = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand     = (int'(rr_ptr) + k) % NUM_CORES;
      cand_idx = PTR_W'(cand);
      if (!win_found && core_req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // A grant happens only when someone is asking and the pipeline is not stalled.
  always_comb begin
    do_grant      = win_found && !stall;
    gnt_onehot    = NUM_CORES'(1) << win_idx;
    rvalid_onehot = issue_vld ? (NUM_CORES'(1) << issue_tag) : '0;
  end

  // Issue and response pipeline. A reset drops any fetch still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      core_gnt    <= '0;
      core_rvalid <= '0;
      iram_addr   <= '0;
      issue_vld   <= 1'b0;
      issue_tag   <= '0;
    end else begin
      // A response always completes one cycle after its grant, stall or not.
      core_rvalid <= rvalid_onehot;
      if (do_grant) begin
        core_gnt  <= gnt_onehot;
        iram_addr <= addr_arr[win_idx];
        issue_vld <= 1'b1;
        issue_tag <= win_idx;
        rr_ptr    <= win_idx;
      end else begin
        // iram_addr and rr_ptr deliberately hold their values here.
        core_gnt  <= '0;
        issue_vld <= 1'b0;
      end
    end
  end

  // At most one grant and one response tag per cycle.
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(core_gnt));

  a_rvalid_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(core_rvalid));

  // Every grant is answered on the very next cycle, for the same core.
  a_gnt_then_rvalid : assert property (@(posedge clk) disable iff (!rst_n)
    (core_gnt != '0) |=> (core_rvalid == $past(core_gnt)));

endmodule

// File: tb/tb_iram_fetch_arbiter.sv
// Directed testbench for iram_fetch_arbiter with a behavioural 1-cycle IRAM.
module tb_iram_fetch_arbiter;

  localparam int NC = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             stall = 1'b0;
  logic [NC-1:0]    core_req = '0;
  logic [NC*AW-1:0] core_addr = '0;
  logic [NC-1:0]    core_gnt;
  logic [NC-1:0]    core_rvalid;
  logic [DW-1:0]    core_rdata;
  logic [AW-1:0]    iram_addr;
  logic [DW-1:0]    iram_data_in;
  logic [DW-1:0]    iram_rdata;

  logic [DW-1:0]    ram [0:65535];
  logic [DW-1:0]    exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  iram_fetch_arbiter #(
    .NUM_CORES (NC),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .core_req     (core_req),
    .core_addr    (core_addr),
    .core_gnt     (core_gnt),
    .core_rvalid  (core_rvalid),
    .core_rdata   (core_rdata),
    .iram_addr    (iram_addr),
    .iram_data_in (iram_data_in),
    .iram_rdata   (iram_rdata)
  );

  // ---------------- clock / reset / IRAM model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) iram_rdata <= ram[iram_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    core_addr[i*AW +: AW] = a;
  endtask

  task automatic apply_reset;
    rst_n     = 1'b0;
    stall     = 1'b0;
    core_req  = '0;
    core_addr = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pulses(input string tag, input logic [31:0] gnt_exp, input logic [31:0] rv_exp);
    check_eq({tag, "_gnt"}, 32'(core_gnt), gnt_exp);
    check_eq({tag, "_rvalid"}, 32'(core_rvalid), rv_exp);
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] stream_tbl [6];
  logic [DW-1:0] fair_tbl [4];
  int            n_gnt;
  logic [DW-1:0] exp_word;

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = '0;
    for (int i = 0; i < 16; i++) ram[i] = 16'hA000 + 16'(i);
    ram[0]        = 16'd32;
    ram[1]        = 16'd11;
    ram[5]        = 16'd7;
    ram[16'hFFFF] = 16'h5A5A;

    stream_tbl = '{16'd32, 16'd11, 16'hA002, 16'hA003, 16'hA004, 16'd7};
    fair_tbl   = '{16'd32, 16'd11, 16'hA002, 16'hA003};

    // Reset state (first posedge already happened with rst_n low).
    @(negedge clk);
    check_eq("rst_gnt", 32'(core_gnt), 0);
    check_eq("rst_rvalid", 32'(core_rvalid), 0);
    check_eq("rst_iram_addr", 32'(iram_addr), 0);
    check_eq("rst_iram_data_in", 32'(iram_data_in), 0);
    tick();
    rst_n = 1'b1;

    // 1. Single request from core0 at address 0 for one cycle.
    core_req = 4'b0001;
    set_addr(0, 16'd0);
    tick();
    check_pulses("t1_c0", 'h1, 'h0);
    check_eq("t1_iram_addr", 32'(iram_addr), 0);
    core_req = '0;
    tick();
    check_pulses("t1_c1", 'h0, 'h1);
    check_eq("t1_rdata", 32'(core_rdata), 32);
    tick();
    check_pulses("t1_c2", 'h0, 'h0);

    // 2. Contention right after reset: core1 first, then core0, no idle cycle.
    apply_reset();
    core_req = 4'b0011;
    set_addr(0, 16'd0);
    set_addr(1, 16'd1);
    tick();
    check_pulses("t2_c0", 'h2, 'h0);
    check_eq("t2_addr_c0", 32'(iram_addr), 1);
    core_req = 4'b0001;
    tick();
    check_pulses("t2_c1", 'h1, 'h2);
    check_eq("t2_addr_c1", 32'(iram_addr), 0);
    check_eq("t2_rdata_c1", 32'(core_rdata), 11);
    core_req = '0;
    tick();
    check_pulses("t2_c2", 'h0, 'h1);
    check_eq("t2_rdata_c2", 32'(core_rdata), 32);
    tick();
    check_pulses("t2_c3", 'h0, 'h0);

    // 3. Streaming: core2 keeps requesting, address advances on each grant.
    apply_reset();
    exp_q.delete();
    n_gnt    = 0;
    core_req = 4'b0100;
    set_addr(2, 16'd0);
    for (int c = 0; c < 8; c++) begin
      tick();
      check_pulses($sformatf("t3_c%0d", c),
                   (c < 6) ? 'h4 : 'h0,
                   (c >= 1 && c <= 6) ? 'h4 : 'h0);
      if (core_rvalid[2]) begin
        if (exp_q.size() > 0) begin
          exp_word = exp_q.pop_front();
          check_eq($sformatf("t3_rdata_c%0d", c), 32'(core_rdata), 32'(exp_word));
        end else begin
          check_eq("t3_unexpected_rvalid", 32'(core_rvalid), 0);
        end
      end
      if (core_gnt[2] && c < 6) exp_q.push_back(stream_tbl[c]);
      if (core_gnt[2]) n_gnt++;
      set_addr(2, 16'(n_gnt));
      core_req = (n_gnt < 6) ? 4'b0100 : 4'b0000;
    end
    check_eq("t3_queue_empty", 32'(exp_q.size()), 0);

    // 4. Fairness: all cores request continuously, grants rotate 1,2,3,0.
    apply_reset();
    core_req = 4'b1111;
    for (int i = 0; i < NC; i++) set_addr(i, 16'(i));
    for (int c = 0; c < 9; c++) begin
      tick();
      check_eq($sformatf("t4_gnt_c%0d", c), 32'(core_gnt),
               (c < 8) ? 32'(1 << ((c + 1) % 4)) : 0);
      if (c >= 1) begin
        check_eq($sformatf("t4_rvalid_c%0d", c), 32'(core_rvalid), 32'(1 << (c % 4)));
        check_eq($sformatf("t4_rdata_c%0d", c), 32'(core_rdata), 32'(fair_tbl[c % 4]));
      end
      if (c == 7) core_req = '0;
    end

    // 5. Stall: in-flight response still lands, new grant waits for stall to drop.
    apply_reset();
    core_req = 4'b0001;
    set_addr(0, 16'd5);
    tick();
    check_pulses("t5_c0", 'h1, 'h0);
    check_eq("t5_addr_c0", 32'(iram_addr), 5);
    core_req = 4'b1000;
    set_addr(3, 16'd1);
    stall = 1'b1;
    tick();
    check_pulses("t5_s1", 'h0, 'h1);
    check_eq("t5_rdata_s1", 32'(core_rdata), 7);
    tick();
    check_pulses("t5_s2", 'h0, 'h0);
    check_eq("t5_addr_hold_s2", 32'(iram_addr), 5);
    tick();
    check_pulses("t5_s3", 'h0, 'h0);
    check_eq("t5_addr_hold_s3", 32'(iram_addr), 5);
    stall = 1'b0;
    tick();
    check_pulses("t5_go", 'h8, 'h0);
    check_eq("t5_addr_go", 32'(iram_addr), 1);
    core_req = '0;
    tick();
    check_pulses("t5_resp", 'h0, 'h8);
    check_eq("t5_rdata_resp", 32'(core_rdata), 11);

    // 6. Reset right after gnt[1]: the fetch is dropped, pointer restarts.
    apply_reset();
    core_req = 4'b0010;
    set_addr(1, 16'd1);
    tick();
    check_pulses("t6_c0", 'h2, 'h0);
    core_req = '0;
    rst_n    = 1'b0;
    #1;
    check_pulses("t6_async", 'h0, 'h0);
    check_eq("t6_async_addr", 32'(iram_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_pulses($sformatf("t6_idle%0d", c), 'h0, 'h0);
    end
    core_req = 4'b0101;
    set_addr(0, 16'd0);
    set_addr(2, 16'd5);
    tick();
    check_pulses("t6_g2", 'h4, 'h0);
    check_eq("t6_addr_g2", 32'(iram_addr), 5);
    core_req = 4'b0001;
    tick();
    check_pulses("t6_g0", 'h1, 'h4);
    check_eq("t6_rdata_g0", 32'(core_rdata), 7);
    core_req = '0;
    tick();
    check_pulses("t6_end", 'h0, 'h1);
    check_eq("t6_rdata_end", 32'(core_rdata), 32);

    // 7. Address 16'hFFFF passes through unmodified.
    apply_reset();
    core_req = 4'b1000;
    set_addr(3, 16'hFFFF);
    tick();
    check_pulses("t7_c0", 'h8, 'h0);
    check_eq("t7_addr", 32'(iram_addr), 'hFFFF);
    check_eq("t7_data_in", 32'(iram_data_in), 0);
    core_req = '0;
    tick();
    check_pulses("t7_c1", 'h0, 'h8);
    check_eq("t7_rdata", 32'(core_rdata), 'h5A5A);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
